// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters with data-hazard
// detection, branch stall and flush/drain control for the decode stage.
module reg_scoreboard #(
  parameter int unsigned NUM_RF    = 16,
  parameter int unsigned CNT_WIDTH = 2
) (
  input  logic              I_CLOCK,
  input  logic              I_RESET,
  input  logic              I_IssueValid,
  input  logic [3:0]        I_Src1Idx,
  input  logic [3:0]        I_Src2Idx,
  input  logic              I_Src1Used,
  input  logic              I_Src2Used,
  input  logic [3:0]        I_DestIdx,
  input  logic              I_DestWrite,
  input  logic              I_IsBranch,
  input  logic              I_BranchResolved,
  input  logic              I_WriteBackEnable,
  input  logic [3:0]        I_WriteBackRegIdx,
  input  logic              I_Flush,
  output logic              O_IssueAccept,
  output logic              O_DepStallSignal,
  output logic              O_BranchStallSignal,
  output logic [NUM_RF-1:0] O_PendingMask,
  output logic [1:0]        O_State,
  output logic              O_Error
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BR_WAIT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_RF];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_RF];
  logic [NUM_RF-1:0]    inc_vec, dec_vec, mask_d, pend_q;
  logic                 err_q, underflow, in_run;
  logic                 src1_haz, src2_haz, dest_haz;

  // Unused encoding 3 behaves exactly like RUN.
  assign in_run = (state_q != BR_WAIT) && (state_q != DRAIN);

  // State register
  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) state_q <= RUN;
    else         state_q <= state_d;
  end

  // Next-state logic; flush dominates every other transition
  always_comb begin
    state_d = state_q;
    if (I_Flush) begin
      state_d = DRAIN;
    end else begin
      case (state_q)
        BR_WAIT: if (I_BranchResolved) state_d = RUN;
        DRAIN:   if (mask_d == '0)     state_d = RUN;
        default: state_d = (O_IssueAccept && I_IsBranch) ? BR_WAIT : RUN;
      endcase
    end
  end

  // Output logic
  always_comb begin
    // A writeback retiring the last pending write bypasses the source hazard.
    src1_haz = I_Src1Used && (cnt_q[I_Src1Idx] != '0) &&
               !(I_WriteBackEnable && (I_WriteBackRegIdx == I_Src1Idx) &&
                 (cnt_q[I_Src1Idx] == CNT_ONE));
    src2_haz = I_Src2Used && (cnt_q[I_Src2Idx] != '0) &&
               !(I_WriteBackEnable && (I_WriteBackRegIdx == I_Src2Idx) &&
                 (cnt_q[I_Src2Idx] == CNT_ONE));
    dest_haz = I_DestWrite && (cnt_q[I_DestIdx] == CNT_MAX);
    O_DepStallSignal    = I_IssueValid && in_run && (src1_haz || src2_haz || dest_haz);
    O_IssueAccept       = I_IssueValid && in_run && !O_DepStallSignal && !I_Flush;
    O_BranchStallSignal = (state_q == BR_WAIT) || (state_q == DRAIN) ||
                          (O_IssueAccept && I_IsBranch);
  end

  assign O_State       = state_q;
  assign O_PendingMask = pend_q;
  assign O_Error       = err_q;

  // Counter update; an increment and decrement of the same register cancel.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    mask_d  = '0;
    if (O_IssueAccept && I_DestWrite) inc_vec[I_DestIdx] = 1'b1;
    if (I_WriteBackEnable)            dec_vec[I_WriteBackRegIdx] = 1'b1;
    for (int unsigned i = 0; i < NUM_RF; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc_vec[i] && !dec_vec[i])
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      else if (dec_vec[i] && !inc_vec[i] && (cnt_q[i] != '0))
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      mask_d[i] = (cnt_d[i] != '0);
    end
    underflow = I_WriteBackEnable && (cnt_q[I_WriteBackRegIdx] == '0);
  end

  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      for (int unsigned i = 0; i < NUM_RF; i++) cnt_q[i] <= '0;
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_RF; i++) cnt_q[i] <= cnt_d[i];
      pend_q <= mask_d;
      if (underflow) err_q <= 1'b1;
    end
  end

endmodule
